// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer encodings, response codes and SRAM slave FSM states.
package ahb_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;
    localparam logic HRESP_OKAY = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_ERR1, ST_ERR2} slv_state_t;
endpackage

// File: rtl/ahb_byte_lane_gen.sv
// ahb_byte_lane_gen: byte-lane write strobes and alignment check for a 32-bit AHB transfer.
module ahb_byte_lane_gen
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr,
    output logic [3:0] strb,
    output logic       misalign
);
    always_comb begin
        strb = hsize == HSIZE_BYTE ? 4'b0001 << addr :
               hsize == HSIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        misalign = (hsize == HSIZE_HALF && addr[0]) || (hsize == HSIZE_WORD && addr != 2'b00);
    end
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite word RAM slave with byte-lane writes, wait states and ERROR responses.
// Optional AHB_SRAM_SLAVE_WRITE_PROTECT_EN rejects user-mode (hprot[1]=0) writes.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int WAIT_STATES     = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic                  hmastlock,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready_broadcast,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  hready,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);
    localparam int IW = $clog2(MEM_DEPTH_WORDS);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("ahb_sram_slave supports DATA_WIDTH=32 only");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("ahb_sram_slave WAIT_STATES must be 0..15");
    end

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];
    slv_state_t            state, nxt;
    logic [3:0]            cnt, strb, strb_a;
    logic [IW-1:0]         idx;
    logic [ADDR_WIDTH-1:0] offs;
    logic                  wr, misalign, wp_err, err, accept;
    logic                  unused;

    ahb_byte_lane_gen u_lane (.hsize(hsize), .addr(haddr[1:0]), .strb(strb_a), .misalign(misalign));

`ifdef AHB_SRAM_SLAVE_WRITE_PROTECT_EN
    assign wp_err = hwrite && !hprot[1];
`else
    assign wp_err = 1'b0;
`endif
    assign unused = &{1'b0, hburst, hmastlock, hprot};

    always_comb begin
        hready = !(state == ST_WAIT || state == ST_ERR1);
        hresp  = state == ST_ERR1 || state == ST_ERR2 ? HRESP_ERROR : HRESP_OKAY;
        hrdata = state == ST_WAIT || state == ST_DONE ? mem[idx] : '0;
    end

    // The range check uses the full offset; the index is truncated only afterwards.
    always_comb begin
        offs   = haddr - base_addr;
        err    = haddr < base_addr || haddr > last_addr || (offs >> 2) >= ADDR_WIDTH'(MEM_DEPTH_WORDS) ||
                 hsize > HSIZE_WORD || misalign || wp_err;
        accept = hsel && hready_broadcast && hready && (htrans == NONSEQ || htrans == SEQ);
        nxt    = state;
        if (hready)
            nxt = !accept ? ST_IDLE : err ? ST_ERR1 : WAIT_STATES == 0 ? ST_DONE : ST_WAIT;
        else if (state == ST_ERR1)
            nxt = ST_ERR2;
        else if (cnt == 4'(WAIT_STATES - 1))
            nxt = ST_DONE;
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= state == ST_WAIT ? cnt + 4'd1 : 4'd0;
        end
        if (accept) begin
            idx  <= offs[IW+1:2];
            strb <= strb_a;
            wr   <= hwrite;
        end
    end

    always_ff @(posedge hclk) begin
        for (int i = 0; i < 4; i++)
            if (hresetn && state == ST_DONE && wr && strb[i])
                mem[idx][8*i +: 8] <= hwdata[8*i +: 8];
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed AHB transfers against a transfer-level model, checked every cycle.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] LAST0 = 32'h1000_0FFF;
    localparam logic [31:0] LAST3 = 32'h1000_FFFF;
`ifdef AHB_SRAM_SLAVE_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    typedef struct {
        logic sel; logic [1:0] tr; logic [31:0] a; logic w; logic [2:0] sz;
        logic [31:0] d; logic [3:0] prot; logic lit_en; logic lit_err; logic [31:0] lit;
    } vec_t;
    typedef struct {logic rdy; logic resp; logic known; logic [31:0] data;} exp_t;

    logic hclk = 1'b0, hresetn = 1'b0;
    always #5 hclk = ~hclk;

    logic        hsel0, hsel3, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic        hr0, hp0, hr3, hp3;
    logic [31:0] hd0, hd3;

    vec_t        vq[$];
    exp_t        eq[$];
    logic [31:0] mm[int];
    int          total = 0, bad = 0, act = 0;
    logic        chk_en = 1'b0;

    ahb_sram_slave #(.WAIT_STATES(0)) u0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(hprot), .hmastlock(1'b0),
        .hwdata(hwdata), .hready_broadcast(hr0), .base_addr(BASE), .last_addr(LAST0),
        .hready(hr0), .hresp(hp0), .hrdata(hd0));

    ahb_sram_slave #(.WAIT_STATES(3)) u3 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(hprot), .hmastlock(1'b0),
        .hwdata(hwdata), .hready_broadcast(hr3), .base_addr(BASE), .last_addr(LAST3),
        .hready(hr3), .hresp(hp3), .hrdata(hd3));

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic add(input logic sel, input logic [1:0] tr, input logic [31:0] a, input logic w,
                       input logic [2:0] sz, input logic [31:0] d, input logic [3:0] prot,
                       input logic lit_en, input logic lit_err, input logic [31:0] lit);
        vec_t v;
        v = '{sel, tr, a, w, sz, d, prot, lit_en, lit_err, lit};
        vq.push_back(v);
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        add(1'b1, NONSEQ, a, 1'b1, sz, d, 4'b0011, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_rd(input logic [31:0] a, input logic [2:0] sz, input logic e, input logic [31:0] lit);
        add(1'b1, NONSEQ, a, 1'b0, sz, 32'h0, 4'b0011, 1'b1, e, lit);
    endtask

    // Transfer-level model: decide the response from the address rules, then queue per-cycle outputs.
    task automatic model_accept(input int inst, input vec_t v);
        logic [31:0] last, off, old, nw, mask;
        logic        err, known;
        int          key, ws, s;
        exp_t        e;
        last = inst != 0 ? LAST3 : LAST0;
        ws   = inst != 0 ? 3 : 0;
        off  = v.a - BASE;
        err  = v.a < BASE || v.a > last || v.sz > 3'd2 || (v.sz == 3'd1 && v.a[0]) ||
               (v.sz == 3'd2 && v.a[1:0] != 2'b00) || off / 4 >= 1024 || (WP && v.w && !v.prot[1]);
        if (v.lit_en) chk("model_err", {31'b0, err}, {31'b0, v.lit_err});
        if (err) begin
            e = '{1'b0, 1'b1, 1'b1, 32'h0}; eq.push_back(e);
            e = '{1'b1, 1'b1, 1'b1, 32'h0}; eq.push_back(e);
            return;
        end
        key   = inst * 4096 + int'(off / 4);
        known = mm.exists(key);
        old   = known ? mm[key] : 32'h0;
        if (v.lit_en && !v.w) chk("model_rdata", old, v.lit);
        for (int c = 0; c < ws; c++) begin
            e = '{1'b0, 1'b0, known, old}; eq.push_back(e);
        end
        e = '{1'b1, 1'b0, known, old}; eq.push_back(e);
        if (v.w && (known || v.sz == 3'd2)) begin
            s    = v.sz == 3'd0 ? 8 * int'(v.a[1:0]) : v.sz == 3'd1 ? 16 * int'(v.a[1]) : 0;
            mask = v.sz == 3'd0 ? 32'hFF << s : v.sz == 3'd1 ? 32'hFFFF << s : 32'hFFFF_FFFF;
            nw   = (old & ~mask) | (v.d & mask);
            mm[key] = nw;
        end
    endtask

    task automatic drive(input vec_t v);
        hsel0  = v.sel && act == 0;
        hsel3  = v.sel && act == 1;
        htrans = v.tr;
        haddr  = v.a;
        hwrite = v.w;
        hsize  = v.sz;
        hprot  = v.prot;
    endtask

    task automatic run(input int inst);
        vec_t cur, idle;
        logic rdy;
        int   i, n;
        n    = vq.size();
        idle = '{1'b0, 2'b00, 32'h0, 1'b0, 3'b0, 32'h0, 4'b0011, 1'b0, 1'b0, 32'h0};
        act  = inst;
        cur  = vq[0];
        drive(cur);
        i = 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge hclk);
            rdy = inst != 0 ? hr3 : hr0;
            @(posedge hclk);
            #1;
            if (rdy) begin
                if (cur.sel && cur.tr[1]) model_accept(inst, cur);
                hwdata = cur.d;
                cur = i < n ? vq[i] : idle;
                i++;
                drive(cur);
            end
            if (i > n && !cur.sel && eq.size() == 0) begin
                vq.delete();
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL run_timeout: inst %0d still busy after 400 cycles", inst);
        vq.delete();
        eq.delete();
    endtask

    always @(negedge hclk) begin
        exp_t e;
        if (chk_en) begin
            if (eq.size() != 0) e = eq.pop_front();
            else e = '{1'b1, 1'b0, 1'b1, 32'h0};
            chk("hready", {31'b0, act != 0 ? hr3 : hr0}, {31'b0, e.rdy});
            chk("hresp", {31'b0, act != 0 ? hp3 : hp0}, {31'b0, e.resp});
            if (e.known) chk("hrdata", act != 0 ? hd3 : hd0, e.data);
            chk("other_idle", {29'b0, act != 0 ? hr0 : hr3, act != 0 ? hp0 : hp3, |(act != 0 ? hd0 : hd3)}, 32'h4);
        end
    end

    initial begin
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = IDLE; haddr = '0; hwrite = 1'b0;
        hsize = HSIZE_WORD; hprot = 4'b0011; hwdata = '0;
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_hready0", {31'b0, hr0}, 32'h1);
        chk("rst_hresp0", {31'b0, hp0}, 32'h0);
        chk("rst_hrdata0", hd0, 32'h0);
        chk("rst_hready3", {31'b0, hr3}, 32'h1);
        chk("rst_hresp3", {31'b0, hp3}, 32'h0);
        chk("rst_hrdata3", hd3, 32'h0);
        hresetn = 1'b1;
        chk_en  = 1'b1;

        do_wr(BASE + 32'h4, HSIZE_WORD, 32'hDEAD_BEEF);
        do_rd(BASE + 32'h4, HSIZE_WORD, 1'b0, 32'hDEAD_BEEF);
        do_wr(BASE + 32'h5, HSIZE_BYTE, 32'h0000_AA00);
        do_rd(BASE + 32'h4, HSIZE_WORD, 1'b0, 32'hDEAD_AAEF);
        do_wr(BASE + 32'h6, HSIZE_HALF, 32'h1234_0000);
        do_rd(BASE + 32'h4, HSIZE_WORD, 1'b0, 32'h1234_AAEF);
        do_wr(BASE + 32'h8, HSIZE_WORD, 32'hCAFE_F00D);
        do_rd(BASE + 32'hA, HSIZE_WORD, 1'b1, 32'h0);
        do_rd(BASE + 32'h8, HSIZE_WORD, 1'b0, 32'hCAFE_F00D);
        do_rd(BASE + 32'h9, HSIZE_BYTE, 1'b0, 32'hCAFE_F00D);
        do_rd(LAST0 + 32'h1, HSIZE_WORD, 1'b1, 32'h0);
        add(1'b1, BUSY, BASE + 32'h8, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF, 4'b0011, 1'b0, 1'b0, 32'h0);
        add(1'b0, NONSEQ, BASE + 32'h8, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF, 4'b0011, 1'b0, 1'b0, 32'h0);
        do_rd(BASE + 32'h8, HSIZE_WORD, 1'b0, 32'hCAFE_F00D);
        add(1'b1, NONSEQ, BASE + 32'h8, 1'b1, 3'b011, 32'h0, 4'b0011, 1'b1, 1'b1, 32'h0);
        do_rd(BASE + 32'h8, HSIZE_WORD, 1'b0, 32'hCAFE_F00D);
        do_rd(BASE + 32'hD, HSIZE_HALF, 1'b1, 32'h0);
        do_rd(BASE - 32'h4, HSIZE_WORD, 1'b1, 32'h0);
        do_wr(LAST0 - 32'h3, HSIZE_WORD, 32'h55AA_55AA);
        do_rd(LAST0 - 32'h3, HSIZE_WORD, 1'b0, 32'h55AA_55AA);
        add(1'b1, NONSEQ, BASE + 32'h8, 1'b1, HSIZE_WORD, 32'h0, 4'b0001, 1'b1, WP, 32'h0);
        do_rd(BASE + 32'h8, HSIZE_WORD, 1'b0, WP ? 32'hCAFE_F00D : 32'h0);
        run(0);

        do_wr(BASE + 32'h20, HSIZE_WORD, 32'h0102_0304);
        do_rd(BASE + 32'h20, HSIZE_WORD, 1'b0, 32'h0102_0304);
        do_rd(BASE + 32'h1000, HSIZE_WORD, 1'b1, 32'h0);
        do_wr(BASE + 32'h10, HSIZE_WORD, 32'h1111_1111);
        do_rd(BASE + 32'h10, HSIZE_WORD, 1'b0, 32'h1111_1111);
        run(1);

        // Abort a wait-stated write with reset; the model never sees it, so the word must keep its value.
        chk_en = 1'b0;
        act    = 1;
        hsel3 = 1'b1; htrans = NONSEQ; haddr = BASE + 32'h10; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge hclk);
        #1;
        hsel3 = 1'b0; htrans = IDLE; hwdata = 32'h2222_2222;
        @(posedge hclk);
        #1;
        chk("wait_hready", {31'b0, hr3}, 32'h0);
        hresetn = 1'b0;
        @(posedge hclk);
        #1;
        chk("abort_hready", {31'b0, hr3}, 32'h1);
        chk("abort_hresp", {31'b0, hp3}, 32'h0);
        chk("abort_hrdata", hd3, 32'h0);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        eq.delete();
        chk_en = 1'b1;
        do_rd(BASE + 32'h10, HSIZE_WORD, 1'b0, 32'h1111_1111);
        run(1);
        repeat (2) @(posedge hclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
